qcldpc_enc_sequencer: RTL and testbench

//  Frame-level controller for the QC-LDPC encoder datapath. Accepts one code-block request
//  (Z select), then paces NUM_INFO_BLKS info blocks in over a valid/ready handshake.

---
 rtl/qcldpc_pkg.sv | 27 ++
 rtl/qcldpc_enc_sequencer_if.sv | 10 +
 rtl/qcldpc_fire_delay.sv | 27 ++
 rtl/qcldpc_enc_sequencer.sv | 131 +++++++++++++
 tb/tb_qcldpc_enc_sequencer.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qcldpc_pkg.sv
// Shared types and constants for the QC-LDPC encoder control path.
package qcldpc_pkg;

  typedef enum logic [3:0] {
    IDLE   = 4'b0000,
    LOAD   = 4'b0001,
    DRAIN  = 4'b0010,
    PARITY = 4'b0100,
    OUTPUT = 4'b1000
  } seq_state_e;

  localparam int NUM_Z_DEFAULT = 3;
  localparam int Z_TABLE [NUM_Z_DEFAULT] = '{27, 54, 81};

  // Widest Z-select vector the index helper understands.
  localparam int MAX_Z = 8;

  function automatic int onehot_to_idx(input logic [MAX_Z-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_Z; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/qcldpc_enc_sequencer_if.sv
// Info-block input and code-block output handshakes of the encoder sequencer.
interface qcldpc_enc_sequencer_if;
  logic in_valid;
  logic in_ready;
  logic out_valid;
  logic out_ready;

  modport master (output in_valid, output out_ready, input in_ready, input out_valid);
  modport slave  (input in_valid, input out_ready, output in_ready, output out_valid);
endinterface

// File: rtl/qcldpc_fire_delay.sv
// Delays the info-block fire strobe by the ROM read latency to form acc_en.
module qcldpc_fire_delay #(
  parameter int DEPTH = 1
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr_q;

  if (DEPTH == 1) begin : g_one
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= din;
    end
  end else begin : g_many
    always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) sr_q <= '0;
      else        sr_q <= {sr_q[DEPTH-2:0], din};
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule

// File: rtl/qcldpc_enc_sequencer.sv
// Frame-level controller of the QC-LDPC encoder: paces info blocks in, steps parity, holds the result.
module qcldpc_enc_sequencer
  import qcldpc_pkg::*;
#(
  parameter int NUM_Z           = 3,
  parameter int NUM_INFO_BLKS   = 20,
  parameter int NUM_PARITY_BLKS = 4,
  parameter int ROM_LATENCY     = 1
) (
  input  logic                                      CLK,
  input  logic                                      rst_n,
  input  logic                                      start,
  input  logic [NUM_Z-1:0]                          req_z,
  output logic                                      cfg_err,
  output logic                                      busy,
  output logic [$clog2(NUM_Z)-1:0]                  z_sel,
  qcldpc_enc_sequencer_if.slave                     bus,
  output logic [$clog2(NUM_Z*NUM_INFO_BLKS)-1:0]    rom_addr,
  output logic                                      acc_clr,
  output logic                                      acc_en,
  output logic                                      par_en,
  output logic [$clog2(NUM_PARITY_BLKS)-1:0]        par_idx
);

  localparam int ADDRW = $clog2(NUM_Z*NUM_INFO_BLKS);
  localparam int ZW    = $clog2(NUM_Z);
  localparam int PW    = $clog2(NUM_PARITY_BLKS);
  localparam int COLW  = $clog2(NUM_INFO_BLKS);
  localparam int DW    = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

  seq_state_e        state_q;
  logic [COLW-1:0]   col_q;
  logic [DW-1:0]     drain_cnt_q;
  logic              out_valid_q;
  logic [MAX_Z-1:0]  req_z_ext;
  logic              fire;

  assign req_z_ext     = MAX_Z'(req_z);
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = out_valid_q;
  assign fire          = bus.in_valid & bus.in_ready;
  assign rom_addr      = ADDRW'(z_sel) * ADDRW'(NUM_INFO_BLKS) + ADDRW'(col_q);

  // Strobes default low each cycle; the state arms exactly the cycles they must be high.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= '0;
      drain_cnt_q <= '0;
      z_sel       <= '0;
      busy        <= 1'b0;
      cfg_err     <= 1'b0;
      acc_clr     <= 1'b0;
      par_en      <= 1'b0;
      par_idx     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      acc_clr <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if ($onehot(req_z)) begin
              state_q <= LOAD;
              busy    <= 1'b1;
              acc_clr <= 1'b1;
              col_q   <= '0;
              z_sel   <= ZW'(onehot_to_idx(req_z_ext));
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (fire) begin
            if (col_q == COLW'(NUM_INFO_BLKS-1)) begin
              col_q       <= '0;
              drain_cnt_q <= '0;
              state_q     <= DRAIN;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        // Hold off parity until the final delayed acc_en has been issued.
        DRAIN: begin
          if (drain_cnt_q == DW'(ROM_LATENCY-1)) begin
            state_q <= PARITY;
            par_en  <= 1'b1;
            par_idx <= '0;
          end else begin
            drain_cnt_q <= drain_cnt_q + 1'b1;
          end
        end
        PARITY: begin
          if (par_idx == PW'(NUM_PARITY_BLKS-1)) begin
            state_q     <= OUTPUT;
            par_en      <= 1'b0;
            par_idx     <= '0;
            out_valid_q <= 1'b1;
          end else begin
            par_idx <= par_idx + 1'b1;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  qcldpc_fire_delay #(
    .DEPTH (ROM_LATENCY)
  ) u_fire_delay (
    .CLK   (CLK),
    .rst_n (rst_n),
    .din   (fire),
    .dout  (acc_en)
  );

  a_state_legal: assert property (@(posedge CLK) disable iff (!rst_n) $onehot0(state_q));
  a_ready_load:  assert property (@(posedge CLK) disable iff (!rst_n) bus.in_ready |-> state_q == LOAD);
  a_zsel_stable: assert property (@(posedge CLK) disable iff (!rst_n) (busy && $past(busy)) |-> $stable(z_sel));
  a_clr_en_excl: assert property (@(posedge CLK) disable iff (!rst_n) !(acc_clr && acc_en));

endmodule

// File: tb/tb_qcldpc_enc_sequencer.sv
// Directed bench for qcldpc_enc_sequencer: two instances, ROM_LATENCY 1 and 3, share one stimulus stream.
module tb_qcldpc_enc_sequencer;

  localparam int NPAR = 4;

  logic       CLK;
  logic       rst_n;
  logic       start;
  logic [2:0] req_z;
  logic       in_valid;
  logic       out_ready;

  logic       cfg_err_o   [2];
  logic       busy_o      [2];
  logic [1:0] z_sel_o     [2];
  logic [5:0] rom_addr_o  [2];
  logic       acc_clr_o   [2];
  logic       acc_en_o    [2];
  logic       par_en_o    [2];
  logic [1:0] par_idx_o   [2];
  logic       in_ready_o  [2];
  logic       out_valid_o [2];

  int         lat [2] = '{1, 3};
  int         checks;
  int         failures;
  int         cyc;
  logic [7:0] fire_hist [2];
  int         last_fire [2];
  int         fire_cnt  [2];
  int         par_cnt   [2];
  logic       ov_prev   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    qcldpc_enc_sequencer_if bus ();
    assign bus.in_valid   = in_valid;
    assign bus.out_ready  = out_ready;
    assign in_ready_o[g]  = bus.in_ready;
    assign out_valid_o[g] = bus.out_valid;

    qcldpc_enc_sequencer #(
      .ROM_LATENCY ((g == 0) ? 1 : 3)
    ) dut (
      .CLK      (CLK),
      .rst_n    (rst_n),
      .start    (start),
      .req_z    (req_z),
      .cfg_err  (cfg_err_o[g]),
      .busy     (busy_o[g]),
      .z_sel    (z_sel_o[g]),
      .bus      (bus),
      .rom_addr (rom_addr_o[g]),
      .acc_clr  (acc_clr_o[g]),
      .acc_en   (acc_en_o[g]),
      .par_en   (par_en_o[g]),
      .par_idx  (par_idx_o[g])
    );
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      failures++;
      $display("[TB] FAIL %s: observed %0d expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  task automatic resetModel();
    for (int d = 0; d < 2; d++) begin
      fire_hist[d] = '0;
      last_fire[d] = 0;
      fire_cnt[d]  = 0;
      par_cnt[d]   = 0;
      ov_prev[d]   = 1'b0;
    end
  endtask

  // Advance one clock; the reference model tracks fires and checks acc_en, parity stepping and latency.
  task automatic step();
    for (int d = 0; d < 2; d++) begin
      fire_hist[d] = {fire_hist[d][6:0], in_valid & in_ready_o[d]};
      if (in_valid && in_ready_o[d]) begin
        last_fire[d] = cyc;
        fire_cnt[d]++;
      end
    end
    @(posedge CLK);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("acc_en%0d", d), int'(acc_en_o[d]), int'(fire_hist[d][lat[d]-1]));
      if (par_en_o[d]) begin
        if (par_cnt[d] == 0)
          checkOutput($sformatf("par_start%0d", d), cyc - last_fire[d], lat[d] + 1);
        checkOutput($sformatf("par_idx%0d", d), int'(par_idx_o[d]), par_cnt[d]);
        par_cnt[d]++;
      end
      if (out_valid_o[d] && !ov_prev[d]) begin
        checkOutput($sformatf("ov_latency%0d", d), cyc - last_fire[d], lat[d] + NPAR + 1);
        checkOutput($sformatf("par_count%0d", d), par_cnt[d], NPAR);
        par_cnt[d] = 0;
      end
      ov_prev[d] = out_valid_o[d];
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] rz, input logic iv, input logic ordy);
    start     = s;
    req_z     = rz;
    in_valid  = iv;
    out_ready = ordy;
    step();
  endtask

  task automatic checkAllZero(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_busy%0d", tag, d),      int'(busy_o[d]), 0);
      checkOutput($sformatf("%s_cfg_err%0d", tag, d),   int'(cfg_err_o[d]), 0);
      checkOutput($sformatf("%s_z_sel%0d", tag, d),     int'(z_sel_o[d]), 0);
      checkOutput($sformatf("%s_rom_addr%0d", tag, d),  int'(rom_addr_o[d]), 0);
      checkOutput($sformatf("%s_acc_clr%0d", tag, d),   int'(acc_clr_o[d]), 0);
      checkOutput($sformatf("%s_acc_en%0d", tag, d),    int'(acc_en_o[d]), 0);
      checkOutput($sformatf("%s_par_en%0d", tag, d),    int'(par_en_o[d]), 0);
      checkOutput($sformatf("%s_par_idx%0d", tag, d),   int'(par_idx_o[d]), 0);
      checkOutput($sformatf("%s_in_ready%0d", tag, d),  int'(in_ready_o[d]), 0);
      checkOutput($sformatf("%s_out_valid%0d", tag, d), int'(out_valid_o[d]), 0);
    end
  endtask

  task automatic checkFrameStart(input string tag, input int zidx);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s_acc_clr%0d", tag, d),  int'(acc_clr_o[d]), 1);
      checkOutput($sformatf("%s_busy%0d", tag, d),     int'(busy_o[d]), 1);
      checkOutput($sformatf("%s_z_sel%0d", tag, d),    int'(z_sel_o[d]), zidx);
      checkOutput($sformatf("%s_in_ready%0d", tag, d), int'(in_ready_o[d]), 1);
      checkOutput($sformatf("%s_rom_addr%0d", tag, d), int'(rom_addr_o[d]), zidx * 20);
    end
  endtask

  task automatic runLoad(input int base, input int n, input logic ordy);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("rom_addr%0d", d), int'(rom_addr_o[d]), base + k);
        if (k > 0) checkOutput($sformatf("acc_clr_once%0d", d), int'(acc_clr_o[d]), 0);
      end
      applyStimulus(1'b0, 3'b000, 1'b1, ordy);
    end
  endtask

  task automatic waitIdle(input int bound);
    int i;
    i = 0;
    while ((busy_o[0] || busy_o[1]) && i < bound) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
      i++;
    end
    checkOutput("idle_reached", int'(busy_o[0] || busy_o[1]), 0);
  endtask

  initial begin
    logic [39:0] pat;
    int          i;
    checks    = 0;
    failures  = 0;
    cyc       = 0;
    start     = 1'b0;
    req_z     = 3'b000;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    resetModel();
    repeat (2) @(posedge CLK);
    #1;
    checkAllZero("reset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);

    // Back-to-back frame on Z index 1
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b1);
    checkFrameStart("f1", 1);
    runLoad(20, 20, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("drain_ready%0d", d), int'(in_ready_o[d]), 0);
      checkOutput($sformatf("f1_fires%0d", d), fire_cnt[d], 20);
    end
    waitIdle(40);

    // Non-one-hot requests are rejected with a single cfg_err pulse
    applyStimulus(1'b1, 3'b011, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("cfg_err%0d", d), int'(cfg_err_o[d]), 1);
      checkOutput($sformatf("cfg_busy%0d", d), int'(busy_o[d]), 0);
      checkOutput($sformatf("cfg_acc_clr%0d", d), int'(acc_clr_o[d]), 0);
    end
    applyStimulus(1'b1, 3'b000, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("cfg_err_zero%0d", d), int'(cfg_err_o[d]), 1);
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("cfg_err_pulse%0d", d), int'(cfg_err_o[d]), 0);
      checkOutput($sformatf("cfg_idle%0d", d), int'(busy_o[d]), 0);
    end

    // Gappy in_valid on Z index 2: col must hold across gaps
    resetModel();
    pat = 40'hA5_5A_C3_3C_96;
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b1);
    checkFrameStart("f3", 2);
    i = 0;
    while (fire_cnt[0] < 20 && i < 100) begin
      for (int d = 0; d < 2; d++)
        if (in_ready_o[d])
          checkOutput($sformatf("gap_rom_addr%0d", d), int'(rom_addr_o[d]), 40 + fire_cnt[d]);
      applyStimulus(1'b0, 3'b000, pat[i % 40], 1'b1);
      i++;
    end
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("f3_fires%0d", d), fire_cnt[d], 20);
    waitIdle(40);

    // Downstream stall: out_valid holds, start is ignored until back in IDLE
    resetModel();
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b0);
    runLoad(20, 20, 1'b0);
    i = 0;
    while (!(out_valid_o[0] && out_valid_o[1]) && i < 20) begin
      applyStimulus(1'b0, 3'b000, 1'b0, 1'b0);
      i++;
    end
    for (int k = 0; k < 10; k++) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("hold_out_valid%0d", d), int'(out_valid_o[d]), 1);
        checkOutput($sformatf("hold_in_ready%0d", d), int'(in_ready_o[d]), 0);
        checkOutput($sformatf("hold_z_sel%0d", d), int'(z_sel_o[d]), 1);
      end
      applyStimulus(1'b1, 3'b100, 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 3'b100, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("handoff_busy%0d", d), int'(busy_o[d]), 0);
      checkOutput($sformatf("handoff_out_valid%0d", d), int'(out_valid_o[d]), 0);
    end
    applyStimulus(1'b0, 3'b000, 1'b0, 1'b1);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("start_ignored%0d", d), int'(busy_o[d]), 0);
      checkOutput($sformatf("start_ignored_clr%0d", d), int'(acc_clr_o[d]), 0);
    end

    // Asynchronous reset in the middle of LOAD, then a clean restart
    resetModel();
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b1);
    runLoad(20, 7, 1'b1);
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("pre_reset_addr%0d", d), int'(rom_addr_o[d]), 27);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async");
    in_valid = 1'b0;
    start    = 1'b0;
    resetModel();
    @(posedge CLK);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'b010, 1'b0, 1'b1);
    checkFrameStart("restart", 1);
    runLoad(20, 20, 1'b1);
    waitIdle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
